// File: rtl/control_fsm_pkg.sv
// Shared LC-3b types for the MP1 control unit: opcodes, ALU operations, mux selects.
// No logic; types and constants only.
// No flow control of its own.
package control_fsm_pkg;

   // Architectural opcode field IR[15:12]
   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   // ALU function select; ALU_ADD is the idle value
   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_AND,
      ALU_NOT,
      ALU_PASS,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } lc3b_aluop;

   typedef logic [1:0] lc3b_sel4mux;

   // pcmux inputs
   localparam lc3b_sel4mux PCMUX_PC_PLUS2 = 2'd0;
   localparam lc3b_sel4mux PCMUX_BR_ADD   = 2'd1;
   localparam lc3b_sel4mux PCMUX_ALU_OUT  = 2'd2;
   localparam lc3b_sel4mux PCMUX_ZERO     = 2'd3;

   // alumux inputs (ALU operand B)
   localparam lc3b_sel4mux ALUMUX_SR2  = 2'd0;
   localparam lc3b_sel4mux ALUMUX_ADJ6 = 2'd1;
   localparam lc3b_sel4mux ALUMUX_IMM5 = 2'd2;
   localparam lc3b_sel4mux ALUMUX_ZERO = 2'd3;

   // Only whole-word accesses exist in MP1
   localparam logic [1:0] MEM_BYTE_EN_WORD = 2'b11;

endpackage

// File: rtl/control_fsm_if.sv
// Control/status bundle between the MP1 control unit, its datapath and unified memory.
// Pure wiring, zero latency.
// Memory stalls via mem_resp: requests are held until mem_resp is seen.
interface control_fsm_if;
   import control_fsm_pkg::*;

   // status from datapath
   lc3b_opcode  opcode;
   logic        branch_enable;
   logic        imm5_enable;
   logic        imm11_enable;

   // memory handshake
   logic        mem_resp;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;

   // datapath controls
   lc3b_sel4mux pcmux_sel;
   logic        load_pc;
   logic        load_ir;
   logic        load_regfile;
   logic        load_mar;
   logic        load_mdr;
   logic        load_cc;
   logic        storemux_sel;
   lc3b_sel4mux alumux_sel;
   logic        regfilemux_sel;
   logic        marmux_sel;
   logic        mdrmux_sel;
   lc3b_aluop   aluop;

   // control unit side
   modport master (
      input  opcode, branch_enable, imm5_enable, imm11_enable, mem_resp,
      output mem_read, mem_write, mem_byte_enable,
      output pcmux_sel, load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
      output storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel, aluop
   );

   // datapath / memory side
   modport slave (
      output opcode, branch_enable, imm5_enable, imm11_enable, mem_resp,
      input  mem_read, mem_write, mem_byte_enable,
      input  pcmux_sel, load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
      input  storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel, aluop
   );

endinterface

// File: rtl/control_fsm.sv
// Multicycle Moore control unit for the LC-3b MP1 core (ADD/AND/NOT/BR/JMP/LDR/STR).
// 5 cycles ALU/JMP/BR-not-taken, 6 BR taken, 7 LDR/STR, plus one per memory wait cycle.
// Memory states hold mem_read/mem_write until mem_resp; reset aborts any access at once.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   control_fsm_if.master bus
);

   typedef enum logic [3:0] {
      FETCH1,
      FETCH2,
      FETCH3,
      DECODE,
      ADD,
      AND,
      NOT,
      BR,
      BR_TAKEN,
      JMP,
      CALC_ADDR,
      LDR1,
      LDR2,
      STR1,
      STR2
   } state_t;

   state_t state;
   state_t next_state;

   // Word accesses only, independent of state
   assign bus.mem_byte_enable = MEM_BYTE_EN_WORD;

   // State register; reset restarts instruction fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH1;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: sequencing, opcode dispatch and memory wait loops
   always_comb begin
      next_state = state;
      case (state)
         FETCH1:    next_state = FETCH2;
         FETCH2:    next_state = bus.mem_resp ? FETCH3 : FETCH2;
         FETCH3:    next_state = DECODE;
         DECODE: begin
            case (bus.opcode)
               op_add:         next_state = ADD;
               op_and:         next_state = AND;
               op_not:         next_state = NOT;
               op_br:          next_state = BR;
               op_jmp:         next_state = JMP;
               op_ldr, op_str: next_state = CALC_ADDR;
               default:        next_state = FETCH1;   // unsupported opcodes retire as NOPs
            endcase
         end
         BR:        next_state = bus.branch_enable ? BR_TAKEN : FETCH1;
         CALC_ADDR: next_state = (bus.opcode == op_ldr) ? LDR1 : STR1;
         LDR1:      next_state = bus.mem_resp ? LDR2 : LDR1;
         STR1:      next_state = STR2;
         STR2:      next_state = bus.mem_resp ? FETCH1 : STR2;
         default:   next_state = FETCH1;              // ADD/AND/NOT/BR_TAKEN/JMP/LDR2
      endcase
   end

   // Output decode from current state; everything held idle while reset is high
   always_comb begin
      bus.pcmux_sel      = PCMUX_PC_PLUS2;
      bus.load_pc        = 1'b0;
      bus.load_ir        = 1'b0;
      bus.load_regfile   = 1'b0;
      bus.load_mar       = 1'b0;
      bus.load_mdr       = 1'b0;
      bus.load_cc        = 1'b0;
      bus.storemux_sel   = 1'b0;
      bus.alumux_sel     = ALUMUX_SR2;
      bus.regfilemux_sel = 1'b0;
      bus.marmux_sel     = 1'b0;
      bus.mdrmux_sel     = 1'b0;
      bus.aluop          = ALU_ADD;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      if (!reset) begin
         case (state)
            FETCH1: begin
               bus.marmux_sel = 1'b1;
               bus.load_mar   = 1'b1;
               bus.pcmux_sel  = PCMUX_PC_PLUS2;
               bus.load_pc    = 1'b1;
            end
            FETCH2: begin
               bus.mem_read   = 1'b1;
               bus.mdrmux_sel = 1'b1;
               bus.load_mdr   = bus.mem_resp;
            end
            FETCH3: begin
               bus.load_ir = 1'b1;
            end
            ADD, AND: begin
               bus.aluop          = (state == AND) ? ALU_AND : ALU_ADD;
               bus.alumux_sel     = bus.imm5_enable ? ALUMUX_IMM5 : ALUMUX_SR2;
               bus.load_regfile   = 1'b1;
               bus.regfilemux_sel = 1'b0;
               bus.load_cc        = 1'b1;
            end
            NOT: begin
               bus.aluop        = ALU_NOT;
               bus.load_regfile = 1'b1;
               bus.load_cc      = 1'b1;
            end
            BR_TAKEN: begin
               bus.pcmux_sel = PCMUX_BR_ADD;
               bus.load_pc   = 1'b1;
            end
            JMP: begin
               bus.aluop     = ALU_PASS;
               bus.pcmux_sel = PCMUX_ALU_OUT;
               bus.load_pc   = 1'b1;
            end
            CALC_ADDR: begin
               bus.alumux_sel = ALUMUX_ADJ6;
               bus.aluop      = ALU_ADD;
               bus.marmux_sel = 1'b0;
               bus.load_mar   = 1'b1;
            end
            LDR1: begin
               bus.mem_read   = 1'b1;
               bus.mdrmux_sel = 1'b1;
               bus.load_mdr   = bus.mem_resp;
            end
            LDR2: begin
               bus.regfilemux_sel = 1'b1;
               bus.load_regfile   = 1'b1;
               bus.load_cc        = 1'b1;
            end
            STR1: begin
               bus.storemux_sel = 1'b1;
               bus.aluop        = ALU_PASS;
               bus.mdrmux_sel   = 1'b0;
               bus.load_mdr     = 1'b1;
            end
            STR2: begin
               bus.mem_write = 1'b1;
            end
            default: ;                                // DECODE, BR: no outputs
         endcase
      end
   end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-cycle control words checked against an instruction-level trace model.
// Inputs driven at the falling edge, outputs sampled 1 time unit later.
// Memory response timing is randomised per access.
module tb_control_fsm;
   import control_fsm_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   control_fsm_if bus();

   control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every control output the bench checks, in one word
   typedef struct packed {
      logic [1:0] pcmux;
      logic       load_pc;
      logic       load_ir;
      logic       load_regfile;
      logic       load_mar;
      logic       load_mdr;
      logic       load_cc;
      logic       storemux;
      logic [1:0] alumux;
      logic       regfilemux;
      logic       marmux;
      logic       mdrmux;
      logic [2:0] aluop;
      logic       mem_read;
      logic       mem_write;
   } ctl_t;

   // One clock cycle of expected behaviour plus the inputs to apply in it
   typedef struct packed {
      ctl_t       ctl;
      logic       resp;
      logic       str2;
      logic [3:0] op;
      logic       imm5;
      logic       br;
   } step_t;

   step_t      plan[$];
   logic [3:0] cur_op;
   logic       cur_imm5;
   logic       cur_br;

   function automatic logic coin();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ctl_t sample();
      ctl_t c;
      c.pcmux        = bus.pcmux_sel;
      c.load_pc      = bus.load_pc;
      c.load_ir      = bus.load_ir;
      c.load_regfile = bus.load_regfile;
      c.load_mar     = bus.load_mar;
      c.load_mdr     = bus.load_mdr;
      c.load_cc      = bus.load_cc;
      c.storemux     = bus.storemux_sel;
      c.alumux       = bus.alumux_sel;
      c.regfilemux   = bus.regfilemux_sel;
      c.marmux       = bus.marmux_sel;
      c.mdrmux       = bus.mdrmux_sel;
      c.aluop        = bus.aluop;
      c.mem_read     = bus.mem_read;
      c.mem_write    = bus.mem_write;
      return c;
   endfunction

   task automatic add_step(input ctl_t c, input logic resp, input logic str2);
      step_t s;
      s.ctl  = c;
      s.resp = resp;
      s.str2 = str2;
      s.op   = cur_op;
      s.imm5 = cur_imm5;
      s.br   = cur_br;
      plan.push_back(s);
   endtask

   // Instruction-level model: the cycle-by-cycle control words one instruction produces.
   // fw/ew are wait cycles before mem_resp for the fetch and the data access.
   task automatic build(input logic [3:0] op, input logic imm5, input logic br,
                        input int fw, input int ew);
      ctl_t c;
      cur_op = op; cur_imm5 = imm5; cur_br = br;
      // fetch: MAR<-PC, PC<-PC+2
      c = '0; c.marmux = 1'b1; c.load_mar = 1'b1; c.load_pc = 1'b1;
      add_step(c, coin(), 1'b0);
      // instruction read, MDR captured only with the response
      for (int k = 0; k <= fw; k++) begin
         c = '0; c.mem_read = 1'b1; c.mdrmux = 1'b1; c.load_mdr = (k == fw);
         add_step(c, (k == fw), 1'b0);
      end
      c = '0; c.load_ir = 1'b1;
      add_step(c, coin(), 1'b0);
      c = '0;                                  // decode cycle
      add_step(c, coin(), 1'b0);
      c = '0;
      case (op)
         4'b0001, 4'b0101: begin
            c.aluop = (op == 4'b0001) ? ALU_ADD : ALU_AND;
            c.alumux = imm5 ? 2'd2 : 2'd0;
            c.load_regfile = 1'b1; c.load_cc = 1'b1;
            add_step(c, coin(), 1'b0);
         end
         4'b1001: begin
            c.aluop = ALU_NOT; c.load_regfile = 1'b1; c.load_cc = 1'b1;
            add_step(c, coin(), 1'b0);
         end
         4'b0000: begin
            add_step(c, coin(), 1'b0);         // condition evaluation
            if (br) begin
               c.pcmux = 2'd1; c.load_pc = 1'b1;
               add_step(c, coin(), 1'b0);
            end
         end
         4'b1100: begin
            c.aluop = ALU_PASS; c.pcmux = 2'd2; c.load_pc = 1'b1;
            add_step(c, coin(), 1'b0);
         end
         4'b0110, 4'b0111: begin
            c.alumux = 2'd1; c.load_mar = 1'b1;  // MAR <- base + offset6
            add_step(c, coin(), 1'b0);
            if (op == 4'b0110) begin
               for (int k = 0; k <= ew; k++) begin
                  c = '0; c.mem_read = 1'b1; c.mdrmux = 1'b1; c.load_mdr = (k == ew);
                  add_step(c, (k == ew), 1'b0);
               end
               c = '0; c.regfilemux = 1'b1; c.load_regfile = 1'b1; c.load_cc = 1'b1;
               add_step(c, coin(), 1'b0);
            end else begin
               c = '0; c.storemux = 1'b1; c.aluop = ALU_PASS; c.load_mdr = 1'b1;
               add_step(c, coin(), 1'b0);
               for (int k = 0; k <= ew; k++) begin
                  c = '0; c.mem_write = 1'b1;
                  add_step(c, (k == ew), 1'b1);
               end
            end
         end
         default: ;                            // NOP: back to fetch after decode
      endcase
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         bus.mem_resp = 1'b1;
         #1;
         n_tests++;
         if (sample() !== ctl_t'(0)) begin
            n_fail++;
            $display("FAIL reset cycle %0d: got %h want %h", i, sample(), ctl_t'(0));
         end
         @(negedge clk);
      end
      reset = 1'b0;
   endtask

   task automatic test_alu();
      build(4'b0001, 1'b0, 1'b0, 0, 0);        // ADD R1,R2,R3
      build(4'b0001, 1'b1, 1'b1, 0, 0);        // ADD immediate
      build(4'b0101, 1'b1, 1'b0, 1, 0);        // AND immediate, one fetch wait
      build(4'b0101, 1'b0, 1'b1, 0, 0);
      build(4'b1001, 1'b1, 1'b0, 0, 0);        // NOT
      foreach (plan[i]) begin
         bus.opcode = lc3b_opcode'(plan[i].op); bus.imm5_enable = plan[i].imm5;
         bus.branch_enable = plan[i].br; bus.mem_resp = plan[i].resp; bus.imm11_enable = coin();
         #1;
         n_tests++;
         if (sample() !== plan[i].ctl) begin
            n_fail++;
            $display("FAIL alu step %0d: got %h want %h", i, sample(), plan[i].ctl);
         end
         @(negedge clk);
      end
      plan.delete();
   endtask

   task automatic test_branch_jmp();
      build(4'b0000, 1'b0, 1'b1, 0, 0);        // BR taken
      build(4'b0000, 1'b1, 1'b0, 0, 0);        // BR not taken
      build(4'b1100, 1'b0, 1'b1, 2, 0);        // JMP
      build(4'b0000, 1'b0, 1'b1, 1, 0);
      foreach (plan[i]) begin
         bus.opcode = lc3b_opcode'(plan[i].op); bus.imm5_enable = plan[i].imm5;
         bus.branch_enable = plan[i].br; bus.mem_resp = plan[i].resp; bus.imm11_enable = coin();
         #1;
         n_tests++;
         if (sample() !== plan[i].ctl) begin
            n_fail++;
            $display("FAIL branch step %0d: got %h want %h", i, sample(), plan[i].ctl);
         end
         @(negedge clk);
      end
      plan.delete();
   endtask

   task automatic test_mem();
      build(4'b0110, 1'b0, 1'b0, 0, 3);        // LDR, response on 4th request cycle
      build(4'b0111, 1'b1, 1'b1, 0, 2);        // STR with waits
      build(4'b0110, 1'b1, 1'b0, 0, 0);        // LDR, immediate response
      build(4'b0111, 1'b0, 1'b0, 0, 0);        // STR, immediate response
      foreach (plan[i]) begin
         bus.opcode = lc3b_opcode'(plan[i].op); bus.imm5_enable = plan[i].imm5;
         bus.branch_enable = plan[i].br; bus.mem_resp = plan[i].resp; bus.imm11_enable = coin();
         #1;
         n_tests++;
         if (sample() !== plan[i].ctl) begin
            n_fail++;
            $display("FAIL mem step %0d: got %h want %h", i, sample(), plan[i].ctl);
         end
         if (plan[i].str2) begin
            n_tests++;
            if (bus.mem_byte_enable !== 2'b11) begin
               n_fail++;
               $display("FAIL byte_enable step %0d: got %b want 11", i, bus.mem_byte_enable);
            end
         end
         @(negedge clk);
      end
      plan.delete();
   endtask

   task automatic test_nop();
      build(4'b1111, 1'b1, 1'b1, 0, 0);        // TRAP
      build(4'b0010, 1'b0, 1'b1, 0, 0);        // LDB
      build(4'b1110, 1'b1, 1'b0, 1, 0);        // LEA
      build(4'b0100, 1'b0, 1'b0, 0, 0);        // JSR
      foreach (plan[i]) begin
         bus.opcode = lc3b_opcode'(plan[i].op); bus.imm5_enable = plan[i].imm5;
         bus.branch_enable = plan[i].br; bus.mem_resp = plan[i].resp; bus.imm11_enable = coin();
         #1;
         n_tests++;
         if (sample() !== plan[i].ctl) begin
            n_fail++;
            $display("FAIL nop step %0d: got %h want %h", i, sample(), plan[i].ctl);
         end
         @(negedge clk);
      end
      plan.delete();
   endtask

   // Reset while FETCH2 waits for memory: access dropped, no MDR load, fetch restarts
   task automatic test_reset_mid_access();
      ctl_t f1, f2;
      f1 = '0; f1.marmux = 1'b1; f1.load_mar = 1'b1; f1.load_pc = 1'b1;
      f2 = '0; f2.mem_read = 1'b1; f2.mdrmux = 1'b1;
      bus.opcode = op_add; bus.mem_resp = 1'b0;
      #1;
      n_tests++;
      if (sample() !== f1) begin
         n_fail++;
         $display("FAIL rst_mid fetch1: got %h want %h", sample(), f1);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.mem_resp = 1'b0;
         #1;
         n_tests++;
         if (sample() !== f2) begin
            n_fail++;
            $display("FAIL rst_mid wait %0d: got %h want %h", i, sample(), f2);
         end
      end
      @(negedge clk);
      reset = 1'b1; bus.mem_resp = 1'b1;
      #1;
      n_tests++;
      if (sample() !== ctl_t'(0)) begin
         n_fail++;
         $display("FAIL rst_mid abort: got %h want %h", sample(), ctl_t'(0));
      end
      @(negedge clk);
      reset = 1'b0; bus.mem_resp = 1'b1;
      #1;
      n_tests++;
      if (sample() !== f1) begin
         n_fail++;
         $display("FAIL rst_mid restart: got %h want %h", sample(), f1);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         build(4'($urandom_range(0, 15)), coin(), coin(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      end
      foreach (plan[i]) begin
         bus.opcode = lc3b_opcode'(plan[i].op); bus.imm5_enable = plan[i].imm5;
         bus.branch_enable = plan[i].br; bus.mem_resp = plan[i].resp; bus.imm11_enable = coin();
         #1;
         n_tests++;
         if (sample() !== plan[i].ctl) begin
            n_fail++;
            $display("FAIL random step %0d op %b: got %h want %h", i, plan[i].op, sample(), plan[i].ctl);
         end
         if (plan[i].str2) begin
            n_tests++;
            if (bus.mem_byte_enable !== 2'b11) begin
               n_fail++;
               $display("FAIL random byte_enable step %0d: got %b want 11", i, bus.mem_byte_enable);
            end
         end
         @(negedge clk);
      end
      plan.delete();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      bus.opcode = op_br;
      bus.branch_enable = 1'b0;
      bus.imm5_enable = 1'b0;
      bus.imm11_enable = 1'b0;
      bus.mem_resp = 1'b0;
      @(negedge clk);
      test_reset();
      test_alu();
      test_branch_jmp();
      test_mem();
      test_nop();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
